// File: rtl/cache_axi_pkg.sv
// Shared definitions for the cache-side SRAM-like to AXI4 bridges.
// Contents:
//   state_t        bridge FSM states
//   SIZE_*         SRAM-like transfer size encodings
//   AXI_BURST_INCR AXI burst type used for every single-beat transfer
//   AXI_RESP_*     AXI response codes
//   norm_size()    folds the reserved size code 3 onto word
package cache_axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_WR_REQ,
    ST_WR_RESP
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // Size code 3 has no meaning on a 32-bit bus, so it is handled as a word.
  function automatic logic [1:0] norm_size(input logic [1:0] size);
    return (size == 2'b11) ? SIZE_WORD : size;
  endfunction

endpackage

// File: rtl/sram_wstrb_gen.sv
// Byte-lane strobe generator for 32-bit SRAM-like writes.
// Ports:
//   size    in  2  0=byte, 1=half, 2/3=word
//   addr_lo in  2  low two address bits
//   strb    out 4  byte-lane enables (bit n = byte lane n)
module sram_wstrb_gen
  import cache_axi_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] addr_lo,
  output logic [3:0] strb
);

  // Halfwords select a lane pair by addr[1]; addr[0] is ignored for them.
  always_comb begin
    strb = 4'b1111;
    case (size)
      SIZE_BYTE: strb = 4'b0001 << addr_lo;
      SIZE_HALF: strb = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:   strb = 4'b1111;
    endcase
  end

endmodule

// File: rtl/d_sram_axi_bridge.sv
// Data-side SRAM-like (req/addr_ok/data_ok) responder to AXI4 master bridge.
// Each accepted cache request becomes exactly one single-beat AXI read (AR/R)
// or write (AW/W/B); only one transaction is in flight at a time.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   data_req/wr/size/addr/wdata  request from the data cache
//   data_rdata, data_addr_ok, data_data_ok  responses to the data cache
//   ar*, r*                  AXI read address / read data channels
//   aw*, w*, b*              AXI write address / write data / write response channels
module d_sram_axi_bridge
  import cache_axi_pkg::*;
#(
  parameter int                  AXI_ID_W = 4,
  parameter logic [AXI_ID_W-1:0] RD_ID    = 'd1,
  parameter logic [AXI_ID_W-1:0] WR_ID    = 'd1
) (
  input  logic                clk,
  input  logic                rst,
  // SRAM-like side
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [1:0]          data_size,
  input  logic [31:0]         data_addr,
  input  logic [31:0]         data_wdata,
  output logic [31:0]         data_rdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  // AXI read address
  output logic [AXI_ID_W-1:0] arid,
  output logic [31:0]         araddr,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic                arlock,
  output logic [3:0]          arcache,
  output logic [2:0]          arprot,
  output logic                arvalid,
  input  logic                arready,
  // AXI read data
  input  logic [AXI_ID_W-1:0] rid,
  input  logic [31:0]         rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready,
  // AXI write address
  output logic [AXI_ID_W-1:0] awid,
  output logic [31:0]         awaddr,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic                awlock,
  output logic [3:0]          awcache,
  output logic [2:0]          awprot,
  output logic                awvalid,
  input  logic                awready,
  // AXI write data
  output logic [AXI_ID_W-1:0] wid,
  output logic [31:0]         wdata,
  output logic [3:0]          wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  // AXI write response
  input  logic [AXI_ID_W-1:0] bid,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);

  state_t      state;
  state_t      state_next;
  logic        accept;
  logic        aw_fire;
  logic        w_fire;
  logic        aw_done;
  logic        w_done;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [1:0]  req_size;
  logic [3:0]  req_strb;
  logic        unused_resp;

  // Response ids, codes and rlast carry nothing this bridge acts on.
  assign unused_resp = ^{rid, rresp, rlast, bid, bresp};

  assign req_size = norm_size(data_size);

  sram_wstrb_gen u_wstrb_gen (
    .size    (data_size),
    .addr_lo (data_addr[1:0]),
    .strb    (req_strb)
  );

  // State register plus the request latch. The latched copies are the only
  // source for the AXI fields, so the cache may change its inputs freely once
  // addr_ok has been given.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        addr_q  <= (req_size == SIZE_WORD) ? {data_addr[31:2], 2'b00} : data_addr;
        size_q  <= req_size;
        wdata_q <= data_wdata;
        wstrb_q <= req_strb;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else if (state == ST_WR_REQ) begin
        if (aw_fire) aw_done <= 1'b1;
        if (w_fire)  w_done  <= 1'b1;
      end
    end
  end

  // Next state and handshake outputs. AW and W are tracked independently so
  // either may complete first; the move to WR_RESP also counts a handshake
  // happening in the current cycle. addr_ok is masked by rst because it is a
  // combinational echo of data_req in IDLE.
  always_comb begin
    state_next   = state;
    accept       = 1'b0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    arvalid      = 1'b0;
    awvalid      = 1'b0;
    wvalid       = 1'b0;
    rready       = 1'b0;
    bready       = 1'b0;
    aw_fire      = 1'b0;
    w_fire       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (data_req && !rst) begin
          accept       = 1'b1;
          data_addr_ok = 1'b1;
          state_next   = data_wr ? ST_WR_REQ : ST_RD_ADDR;
        end
      end
      ST_RD_ADDR: begin
        arvalid = 1'b1;
        if (arready) state_next = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        rready = 1'b1;
        if (rvalid) begin
          data_data_ok = 1'b1;
          state_next   = ST_IDLE;
        end
      end
      ST_WR_REQ: begin
        awvalid = !aw_done;
        wvalid  = !w_done;
        aw_fire = awvalid && awready;
        w_fire  = wvalid && wready;
        if ((aw_done || aw_fire) && (w_done || w_fire)) state_next = ST_WR_RESP;
      end
      ST_WR_RESP: begin
        bready = 1'b1;
        if (bvalid) begin
          data_data_ok = 1'b1;
          state_next   = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Read data goes straight through; the cache only samples it with data_ok.
  assign data_rdata = rdata;

  assign arid    = RD_ID;
  assign araddr  = addr_q;
  assign arlen   = 8'd0;
  assign arsize  = {1'b0, size_q};
  assign arburst = AXI_BURST_INCR;
  assign arlock  = 1'b0;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;

  assign awid    = WR_ID;
  assign awaddr  = addr_q;
  assign awlen   = 8'd0;
  assign awsize  = {1'b0, size_q};
  assign awburst = AXI_BURST_INCR;
  assign awlock  = 1'b0;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;

  assign wid     = WR_ID;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wlast   = 1'b1;

endmodule
